// File: rtl/uart_tx_dev.sv
// uart_tx_dev: Bridge-mapped 8N1 serial transmitter with byte FIFO and IRQ.
// Define UART_TX_PARITY_EN to add a parity bit (CTRL bit2 selects odd).
module uart_tx_dev #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]    state;
  logic          en;
  logic          ie;
  logic          podd;
  logic          ovf;
  logic [15:0]   div;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [7:0]    shifter;
  logic [2:0]    bitcnt;
  logic [15:0]   bcnt;
  logic [15:0]   pm1;
  logic          bit_end;

  logic sel_data;
  logic sel_ctrl;
  logic sel_div;
  logic empty;
  logic full;
  logic push_req;
  logic push;
  logic pop;
  logic [7:0] head;
  logic [3:0] count4;
  logic unused;

  assign sel_data = WE && (Addr[3:2] == 2'd0);
  assign sel_ctrl = WE && (Addr[3:2] == 2'd1);
  assign sel_div  = WE && (Addr[3:2] == 2'd3);

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (state == IDLE) && en && !empty;
  assign push_req = sel_data;
  assign push     = push_req && (!full || pop);
  assign head     = mem[rptr];
  assign count4   = 4'(count);
  assign unused   = ^{Addr[31:4], Din[31:16]};

  // Shorter divisor takes effect at once: a counter already past it ends the bit
  assign pm1     = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign bit_end = (bcnt >= pm1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en  <= 1'b0;
      ie  <= 1'b0;
      div <= DIV_RESET;
`ifdef UART_TX_PARITY_EN
      podd <= 1'b0;
`endif
    end else begin
      if (sel_ctrl) begin
        en <= Din[0];
        ie <= Din[1];
`ifdef UART_TX_PARITY_EN
        podd <= Din[2];
`endif
      end
      if (sel_div) div <= Din[15:0];
    end
  end

`ifndef UART_TX_PARITY_EN
  assign podd = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= Din[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (sel_ctrl)
        ovf <= 1'b0;
      else if (push_req && !push)
        ovf <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic pbit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pbit <= 1'b0;
    else if (pop)
      pbit <= (^head) ^ podd;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      shifter <= 8'd0;
      bitcnt  <= 3'd0;
      bcnt    <= 16'd0;
    end else begin
      bcnt <= bit_end ? 16'd0 : bcnt + 16'd1;
      case (state)
        IDLE: begin
          bcnt <= 16'd0;
          if (pop) begin
            state   <= START;
            shifter <= head;
            txd     <= 1'b0;
            bitcnt  <= 3'd0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            txd   <= shifter[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= pbit;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              shifter <= {1'b0, shifter[7:1]};
              txd     <= shifter[1];
              bitcnt  <= bitcnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            txd   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // A DATA write in the same cycle keeps IRQ low instead of pulsing it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      IRQ <= 1'b0;
    else
      IRQ <= ie && empty && (state == IDLE) && !sel_data;
  end

  always_comb begin
    Dout = 32'd0;
    unique case (Addr[3:2])
      2'd0: Dout = 32'd0;
      2'd1: Dout = {29'd0, podd, ie, en};
      2'd2: Dout = {24'd0, count4, ovf, (state != IDLE), full, empty};
      2'd3: Dout = {16'd0, div};
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: directed self-checking bench for uart_tx_dev.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_dev;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:2] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int total = 0;
  int bad = 0;
  bit par;
  logic [7:0] seq [4];

  uart_tx_dev dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'd0, a};
    WE   = 1'b1;
    Din  = d;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a,
                         input logic [31:0] exp);
    Addr = {28'd0, a};
    #1;
    chk(tag, Dout, exp);
  endtask

  function automatic logic fbit(input logic [7:0] b, input int i,
                                input bit p, input bit odd);
    logic r;
    if (i == 0)
      r = 1'b0;
    else if (i <= 8)
      r = b[i-1];
    else if (p && i == 9)
      r = (^b) ^ odd;
    else
      r = 1'b1;
    return r;
  endfunction

  task automatic check_frame(input string tag, input logic [7:0] b,
                             input int p, input int nb,
                             input bit pe, input bit odd);
    for (int j = 1; j <= nb * p; j++) begin
      @(negedge clk);
      chk(tag, {31'd0, txd}, {31'd0, fbit(b, (j - 1) / p, pe, odd)});
    end
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    par = 1'b1;
`else
    par = 1'b0;
`endif
    seq[0] = 8'h11;
    seq[1] = 8'h22;
    seq[2] = 8'h33;
    seq[3] = 8'h44;

    // reset
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, IRQ}, 32'd0);
    reset = 1'b1;
    chk_reg("rst_status", 2'd2, 32'h01);
    chk_reg("rst_div", 2'd3, 32'd434);
    chk_reg("rst_ctrl", 2'd1, 32'd0);
    chk_reg("data_reads0", 2'd0, 32'd0);

    // 0xA5 at P=4
    wr(2'd3, 32'd4);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1234_56A5);
    chk("a5_empty_clr", {31'd0, txd}, 32'd1);
    chk_reg("a5_status_n", 2'd2, 32'h10);
    check_frame("a5_bit", 8'hA5, 4, 10, 1'b0, 1'b0);
    chk_reg("a5_busy_end", 2'd2, 32'h05);
    @(negedge clk);
    chk_reg("a5_idle", 2'd2, 32'h01);

    // overflow, then back-to-back frames at P=2
    wr(2'd1, 32'd0);
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    wr(2'd0, 32'h44);
    wr(2'd0, 32'h55);
    chk_reg("ovf_status", 2'd2, 32'h4A);
    wr(2'd2, 32'hFF);
    chk_reg("status_ro", 2'd2, 32'h4A);
    wr(2'd1, 32'd1);
    chk_reg("ovf_clear", 2'd2, 32'h42);
    for (int j = 1; j <= 90; j++) begin
      int k;
      int off;
      logic e;
      @(negedge clk);
      k = (j - 1) / 21;
      off = (j - 1) % 21;
      if (k < 4 && off < 20)
        e = fbit(seq[k], off / 2, 1'b0, 1'b0);
      else
        e = 1'b1;
      chk("b2b_bit", {31'd0, txd}, {31'd0, e});
    end
    chk_reg("b2b_idle", 2'd2, 32'h01);

    // IRQ
    wr(2'd1, 32'd3);
    chk("irq_lag", {31'd0, IRQ}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h00);
    chk("irq_clr_wr", {31'd0, IRQ}, 32'd0);
    repeat (21) @(negedge clk);
    chk("irq_stop_end", {31'd0, IRQ}, 32'd0);
    @(negedge clk);
    chk("irq_return", {31'd0, IRQ}, 32'd1);
    wr(2'd1, 32'd1);
    @(negedge clk);
    chk("irq_ie_off", {31'd0, IRQ}, 32'd0);

    // DIVISOR change mid-bit
    wr(2'd3, 32'd8);
    wr(2'd0, 32'hFF);
    @(negedge clk);
    chk("div_start", {31'd0, txd}, 32'd0);
    repeat (37) @(negedge clk);
    chk("div_bit3", {31'd0, txd}, 32'd1);
    wr(2'd3, 32'd2);
    repeat (10) @(negedge clk);
    chk_reg("div_stop", 2'd2, 32'h05);
    @(negedge clk);
    chk_reg("div_done", 2'd2, 32'h01);

    // async reset mid-frame
    wr(2'd3, 32'd8);
    wr(2'd0, 32'h00);
    wr(2'd0, 32'h55);
    repeat (20) @(negedge clk);
    chk("mid_txd_low", {31'd0, txd}, 32'd0);
    reset = 1'b0;
    #1;
    chk("arst_txd", {31'd0, txd}, 32'd1);
    chk("arst_irq", {31'd0, IRQ}, 32'd0);
    chk_reg("arst_status", 2'd2, 32'h01);
    @(negedge clk);
    reset = 1'b1;
    chk_reg("arst_div", 2'd3, 32'd434);
    chk_reg("arst_ctrl", 2'd1, 32'd0);

    // parity option
    wr(2'd3, 32'd2);
    wr(2'd1, 32'd5);
    chk_reg("par_ctrl", 2'd1, par ? 32'h5 : 32'h1);
    wr(2'd0, 32'h03);
    check_frame("par_bit", 8'h03, 2, par ? 11 : 10, par, 1'b1);
    chk_reg("par_busy_end", 2'd2, 32'h05);
    @(negedge clk);
    chk_reg("par_idle", 2'd2, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_dev.md
# uart_tx_dev

Bridge-mapped serial transmitter that sits beside the two timers downstream of the Bridge. It consumes the Bridge's word-addressed write port (`Addr`/`WE`/`Din`) and returns read data on `Dout`. Bytes written by the CPU are buffered in a small FIFO and shifted out on `txd` as 8N1 frames at a programmable bit period. `IRQ` feeds the CPU's external interrupt inputs exactly as the timer IRQs do.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DIV_RESET`, 16'd434: reset value of the DIVISOR register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0); same port name as the rest of the codebase.
- `Addr`  in  [31:2]  word address from the Bridge; only `Addr[3:2]` is decoded.
- `WE`  in  1  write strobe for the current `Addr`.
- `Din`  in  32  write data.
- `Dout`  out  32  combinational read data for `Addr`.
- `IRQ`  out  1  registered interrupt request.
- `txd`  out  1  serial line, idle high, registered.

## Operation
- Register map (`Addr[3:2]`):
  - 0 DATA: a write pushes `Din[7:0]`; a read returns 0.
  - 1 CTRL: bit0 `en` (transmit enable), bit1 `ie` (IRQ enable). Any CTRL write clears `ovf`.
  - 2 STATUS (read-only): bit0 `empty`, bit1 `full`, bit2 `busy` (state≠IDLE), bit3 `ovf` (sticky), bits[7:4] = `count`.
  - 3 DIVISOR: bits[15:0]. Bit period `P` = max(DIVISOR,1) cycles.
- Unused read bits return 0. Writes to STATUS are ignored.
- FIFO:
  - A push with `count==FIFO_DEPTH` and no same-cycle pop is dropped and sets `ovf`.
  - Push and pop in the same cycle: both happen, `count` is unchanged, and this holds even when full.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START when `en && !empty`: pop the head into the shifter, set `txd<=0`, clear the bit counter.
  - START → DATA after `P` cycles: `txd<=shifter[0]`.
  - DATA: shift LSB first, one bit every `P` cycles. After bit 7 has held `P` cycles, go to STOP (or to PARITY when built), with `txd<=1`.
  - STOP → IDLE after `P` cycles.
- Clearing `en` mid-frame finishes the current frame; no further pops occur.
- A DIVISOR write mid-bit takes effect immediately. The bit ends when the baud counter reaches `P-1`. If the counter is already ≥ the new `P-1`, the bit ends on the next edge.
- `IRQ` is registered: `IRQ <= ie && empty && state==IDLE`. It stays high until data is written or `ie` is cleared.

## Timing
- Reset values: `txd=1`, `IRQ=0`, CTRL=0, DIVISOR=`DIV_RESET`, FIFO empty, `ovf=0`, state IDLE.
- Reset asserted mid-frame drives `txd` to 1 and `IRQ` to 0 immediately (asynchronously) and discards the FIFO contents.
- `Dout` has 0-cycle latency. A read in the same cycle as a write returns the pre-edge value.
- A DATA write at edge N while idle with `en=1`:
  - `empty` clears after edge N.
  - The pop and `txd` falling edge occur at edge N+1.
  - One frame spans 10·`P` cycles (11·`P` with parity).
- Back-to-back frames have exactly one IDLE cycle between the end of STOP and the next START.
- `IRQ` rises one edge after the IDLE-and-empty condition becomes true.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - CTRL bit2 `podd` selects odd (1) or even (0) parity.
  - The PARITY state inserts one bit of `P` cycles between data bit 7 and STOP. The bit is the XOR of the data byte, inverted when `podd`=1.
- Not defined: there is no PARITY state, CTRL bit2 reads 0 and ignores writes, and frames are 8N1.

## Test plan
- Reset: hold `reset=0` for 3 cycles → `txd=1`, `IRQ=0`, STATUS=0x01, DIVISOR reads 434.
- DIVISOR=4, CTRL=1, write DATA 0xA5 → `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total. STATUS then returns 0x01.
- DIVISOR=2, `en=0`, write 5 bytes → STATUS `full=1`, `count=4`, `ovf=1`. Set CTRL=1 → the first 4 bytes go out back-to-back with a 1-cycle gap and `ovf` clears; the 5th byte is never sent.
- CTRL=3 with an empty FIFO → `IRQ=1` one edge later. Write DATA 0x00 → `IRQ=0` after that edge. `IRQ` returns to 1 one edge after the frame's STOP bit ends.
- DIVISOR=8, send 0xFF, write DIVISOR=2 during bit 3 with the counter at 5 → that bit ends on the next edge and later bits last 2 cycles. Pull reset low mid-frame → `txd=1` immediately.
- With `UART_TX_PARITY_EN`, CTRL=5 (`en`, `podd`), send 0x03 → the parity bit is 1 and the frame is 11·`P` cycles. Without the macro → the frame is 10·`P` cycles and CTRL reads 0x1.
